// File: rtl/div_seq_pkg.sv
// Shared types and constants for the sequential divider.
//   DType     - 32-bit data word used on every data port
//   DivState  - divider FSM state encoding (IDLE, BUSY, DONE)
//   DIV_STEPS - number of restoring steps, one per quotient bit
package cpuDefine;

  typedef logic [31:0] DType;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } DivState;

  localparam int DIV_STEPS = 32;

endpackage

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for the execute-stage ALU.
//
// Handshake (responder side): the ALU raises en and holds stable operands for
// the whole instruction. An operation starts when en is seen in IDLE; the
// result appears with a one-cycle complete pulse exactly 34 cycles after the
// request edge. Dropping en in BUSY or DONE aborts: no complete is raised and
// the result registers keep their previous values.
//
// Ports:
//   aclk       in   clock
//   aresetn    in   synchronous active-low reset
//   en         in   request, held high by the ALU while a divide is in the stage
//   is_signed  in   1 = DIV/MOD, 0 = DIVU/MODU (sampled at start)
//   dividend   in   operand A (sampled at start)
//   divisor    in   operand B (sampled at start)
//   quotient   out  registered quotient
//   remainder  out  registered remainder
//   complete   out  one-cycle result-valid pulse
//   busy       out  high while the FSM is in BUSY
module div_seq
  import cpuDefine::*;
#(
  parameter int DATA_W = 32
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic en,
  input  logic is_signed,
  input  DType dividend,
  input  DType divisor,
  output DType quotient,
  output DType remainder,
  output logic complete,
  output logic busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_STEPS - 1);

  DivState          state_q;
  logic [CNT_W-1:0] count_q;
  logic [32:0]      rem_q;       // partial remainder, one spare bit for exact borrow
  DType             quo_q;       // dividend magnitude shifting out, quotient shifting in
  DType             div_q;       // divisor magnitude
  logic             q_neg_q;
  logic             r_neg_q;
  logic             dz_q;
  DType             quotient_q;
  DType             remainder_q;
  logic             complete_q;

  // Conditional two's-complement negate. As an absolute value it maps
  // 0x80000000 onto itself, which is exactly unsigned 2^31.
  function automatic DType cneg(input DType v, input logic neg);
    return neg ? DType'(~v + 32'd1) : v;
  endfunction

  logic        a_neg;
  logic        b_neg;
  logic [33:0] rem_shift;
  logic [33:0] trial;
  logic        borrow;

  always_comb begin
    a_neg     = is_signed & dividend[31];
    b_neg     = is_signed & divisor[31];
    rem_shift = {rem_q, quo_q[31]};
    trial     = rem_shift - {2'b00, div_q};
    // A negative trial difference sets the top bit: the divisor did not fit.
    borrow    = trial[33];
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dz_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      complete_q  <= 1'b0;
    end else begin
      complete_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en) begin
            quo_q   <= cneg(dividend, a_neg);
            div_q   <= cneg(divisor, b_neg);
            rem_q   <= '0;
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
            dz_q    <= (divisor == '0);
            count_q <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (!en) begin
            count_q <= '0;
            state_q <= IDLE;
          end else begin
            rem_q   <= borrow ? rem_shift[32:0] : trial[32:0];
            quo_q   <= {quo_q[30:0], ~borrow};
            count_q <= count_q + 1'b1;
            if (count_q == LAST_STEP) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (en) begin
            // With a zero divisor every trial "succeeds": the magnitude
            // quotient is all ones and the remainder is |dividend|, so the
            // sign fix-up on the remainder restores the original dividend.
            quotient_q  <= dz_q ? '1 : cneg(quo_q, q_neg_q);
            remainder_q <= cneg(rem_q[31:0], r_neg_q);
            complete_q  <= 1'b1;
          end
          count_q <= '0;
          state_q <= IDLE;
        end
        default: begin
          count_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign complete  = complete_q;
  assign busy      = (state_q == BUSY);

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: expected {quotient, remainder} pairs are
// queued when an operation is driven and compared when complete pulses.
module tb_div_seq;

  logic        aclk;
  logic        aresetn;
  logic        en;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        complete;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;

  div_seq #(.DATA_W(32)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .en        (en),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .complete  (complete),
    .busy      (busy)
  );

  // clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model written from the division rules, independent of the RTL.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    int sa;
    int sb;
    int sq;
    int sr;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (!s) return {a / b, a % b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'd0};
    sa = a;
    sb = b;
    sq = sa / sb;
    sr = sa % sb;
    return {sq[31:0], sr[31:0]};
  endfunction

  // driver tasks
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [63:0] e);
    en        = 1'b1;
    dividend  = a;
    divisor   = b;
    is_signed = s;
    exp_q.push_back(e);
  endtask

  // Wait until complete is seen; n counts edges from the first one waited on.
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge aclk);
      #1;
      if (complete) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic collect(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, {quotient, remainder}, e);
      last_q = e[63:32];
      last_r = e[31:0];
    end
  endtask

  // Full operation: request, check latency and result, release, check pulse width.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [63:0] e);
    int n;
    @(negedge aclk);
    drive(a, b, s, e);
    wait_done(n);
    check({tag, "_lat"}, 64'(n), 64'd34);
    if (n != 0) collect(tag);
    @(negedge aclk);
    en = 1'b0;
    @(posedge aclk);
    #1;
    check({tag, "_pulse"}, {63'd0, complete}, 64'd0);
  endtask

  initial begin
    int n;
    int seen;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    aresetn   = 1'b0;
    en        = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge aclk);
    #1;
    check("reset_out", {quotient, remainder}, 64'd0);
    check("reset_flags", {62'd0, complete, busy}, 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;

    run_op("udiv_100_7", 32'd100, 32'd7, 1'b0, {32'd14, 32'd2});
    run_op("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
    run_op("sdiv_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, {32'hFFFF_FFFD, 32'd1});
    run_op("sdiv_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h8000_0000, 32'd0});
    run_op("udiv_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, {32'hFFFF_FFFF, 32'd0});
    run_op("udiv_zero", 32'h1234_5678, 32'd0, 1'b0, {32'hFFFF_FFFF, 32'h1234_5678});
    run_op("sdiv_zero", 32'h1234_5678, 32'd0, 1'b1, {32'hFFFF_FFFF, 32'h1234_5678});
    run_op("sdiv_neg_zero", 32'hFFFF_FF00, 32'd0, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FF00});

    // random operations, expectations from the model
    for (int k = 0; k < 6; k++) begin
      ra = $urandom();
      rb = (k == 0) ? 32'd3 : ($urandom_range(0, 1) == 1 ? $urandom() : 32'($urandom_range(1, 1000)));
      rs = 1'($urandom_range(0, 1));
      run_op($sformatf("rand%0d", k), ra, rb, rs, model(ra, rb, rs));
    end

    // abort 10 cycles into BUSY
    @(negedge aclk);
    en = 1'b1; dividend = 32'd1000; divisor = 32'd10; is_signed = 1'b0;
    repeat (11) @(posedge aclk);
    @(negedge aclk);
    en = 1'b0;
    @(posedge aclk);
    #1;
    check("abort_idle", {62'd0, complete, busy}, 64'd0);
    check("abort_hold", {quotient, remainder}, {last_q, last_r});
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge aclk);
      #1;
      if (complete) seen++;
    end
    check("abort_nocpl", 64'(seen), 64'd0);
    run_op("after_abort", 32'd9, 32'd3, 1'b0, {32'd3, 32'd0});

    // reset mid-BUSY
    @(negedge aclk);
    en = 1'b1; dividend = 32'd77; divisor = 32'd7; is_signed = 1'b0;
    repeat (15) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b0;
    en      = 1'b0;
    @(posedge aclk);
    #1;
    check("rst_mid_out", {quotient, remainder}, 64'd0);
    check("rst_mid_flags", {62'd0, complete, busy}, 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge aclk);
      #1;
      if (complete) seen++;
    end
    check("rst_nocpl", 64'(seen), 64'd0);
    last_q = '0;
    last_r = '0;

    // back-to-back: en stays high, operands change in the complete cycle
    @(negedge aclk);
    drive(32'd50, 32'd5, 1'b0, {32'd10, 32'd0});
    wait_done(n);
    check("b2b_first_lat", 64'(n), 64'd34);
    if (n != 0) collect("b2b_first");
    @(negedge aclk);
    drive(32'd51, 32'd5, 1'b0, {32'd10, 32'd1});
    seen = 0;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge aclk);
      #1;
      if (i == 20) check("b2b_hold", {quotient, remainder}, {last_q, last_r});
      if (complete) begin
        n = i;
        break;
      end
    end
    check("b2b_second_lat", 64'(n), 64'd34);
    if (n != 0) collect("b2b_second");
    @(negedge aclk);
    en = 1'b0;
    @(posedge aclk);
    #1;
    check("b2b_pulse", {63'd0, complete}, 64'd0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle radix-2 integer divider serving the execute-stage ALU through its en/complete handshake. The ALU holds `en` and stable operands while a DIV/DIVU/MOD/MODU instruction occupies the stage. It advances the stage when `complete` is seen. This block is the responder side of that handshake: it computes a 32-bit quotient and remainder, signed or unsigned, with fixed latency, and supports abort on flush.

## Interface
- `DATA_W`, 32: operand width; only 32 is supported.
- `aclk`  in  1  clock.
- `aresetn`  in  1  synchronous, active-low reset.
- `en`  in  1  request; high while the ALU holds a divide instruction.
- `is_signed`  in  1  1 = DIV/MOD semantics, 0 = DIVU/MODU; sampled at start.
- `dividend`  in  32  operand A; sampled at start.
- `divisor`  in  32  operand B; sampled at start.
- `quotient`  out  32  registered result.
- `remainder`  out  32  registered result.
- `complete`  out  1  result valid; one-cycle pulse.
- `busy`  out  1  high in BUSY state, for debug and perf counters.

## Operation
- FSM states:
  - IDLE: if `en`=1, latch |dividend|, |divisor|, quotient sign (signs differ and `is_signed`), remainder sign (dividend sign and `is_signed`), `is_signed`, divisor-zero flag, then go to BUSY with count=0.
  - BUSY: one restoring step per cycle. Shift {rem,quo} left 1, trial-subtract the divisor, keep the result if there is no borrow and set the quotient LSB. On count=31 go to DONE.
  - DONE: apply sign correction, drive the results, assert `complete`, and go to IDLE.
- Abort: `en`=0 in BUSY or DONE returns the FSM to IDLE next cycle. `complete` is never raised for the aborted operation. `quotient` and `remainder` keep their previous values.
- Back-to-back: if `en` is still high in the IDLE cycle after DONE, a new operation starts on the current operands. The ALU drops or changes operands on its advance, so no stale restart is visible.
- Sign rules:
  - quotient is negated if the operand signs differ;
  - remainder takes the sign of the dividend;
  - magnitudes use two's complement, with 0x80000000 treated as unsigned 2^31.
- Divide by zero, signed or unsigned: quotient = 0xFFFFFFFF, remainder = dividend (original, not absolute).
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. This falls out of the magnitude algorithm with no special case.
- Remainder width: the partial remainder register is 33 bits so the trial subtract borrow is exact.

## Timing
- Reset (`aresetn`=0 at a rising edge) sets:
  - state = IDLE;
  - count = 0;
  - `quotient` = 0, `remainder` = 0;
  - `complete` = 0, `busy` = 0.
- Reset mid-operation acts as an abort and discards all progress.
- Latency: `en` sampled high in IDLE at edge E0. BUSY runs for edges E1..E32. `complete` is high in the cycle after E33 (DONE state), so there are 34 cycles from request to the ALU advancing. Latency is fixed and independent of operand values or divide by zero.
- `complete` is registered (a DONE-state decode) and high for exactly one cycle per operation.
- `quotient` and `remainder` are valid in the `complete` cycle and hold until the next DONE or reset.
- `busy` = (state == BUSY).
- Operand changes while BUSY are ignored, because all operands are latched at start.

## Structure
- `cpuDefine` package:
  - `DType` is used for every 32-bit port;
  - add a `DivState` enum (IDLE, BUSY, DONE);
  - add constant `DIV_STEPS` = 32.
- A local helper function computes conditional two's-complement negate/absolute value. It is shared between the operand capture and the result fix-up.
- No sub-module: one FSM, a 5-bit counter, a 33-bit remainder, a 32-bit quotient shift register and a flag register set.

## Test plan
- Unsigned: `en`=1, `is_signed`=0, 100 / 7 → `complete` pulses exactly 34 cycles after `en` rises, quotient 14, remainder 2; `complete` low the following cycle.
- Signed signs: −7 / 2 (0xFFFFFFF9, 0x2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- Signed signs: 7 / −2 → quotient 0xFFFFFFFD, remainder 1.
- Corner values:
  - 0x80000000 / 0xFFFFFFFF signed → quotient 0x80000000, remainder 0;
  - 0xFFFFFFFF / 1 unsigned → quotient 0xFFFFFFFF, remainder 0.
- Divide by zero: 0x12345678 / 0, both `is_signed` values → quotient 0xFFFFFFFF, remainder 0x12345678, same 34-cycle latency.
- Abort and reset:
  - drop `en` 10 cycles into BUSY → no `complete`, outputs unchanged, state IDLE next cycle;
  - then 9 / 3 → quotient 3, remainder 0 after full latency;
  - `aresetn` low for 1 cycle mid-BUSY → all outputs 0, no `complete`.
- Back-to-back: hold `en` high and change operands in the cycle after `complete` (50/5, then 51/5) → second `complete` 34 cycles later with quotient 10, remainder 1; first results held until then.
